// File: rtl/adpcm_pkg.sv
// Shared IMA ADPCM constants, tables and types used by the encoder and its sub-blocks.
package adpcm_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int CODE_W    = 4;
  localparam int MAX_INDEX = 88;

  localparam logic [15:0] STEP_TABLE [0:88] = '{
    16'd7,     16'd8,     16'd9,     16'd10,    16'd11,    16'd12,    16'd13,    16'd14,
    16'd16,    16'd17,    16'd19,    16'd21,    16'd23,    16'd25,    16'd28,    16'd31,
    16'd34,    16'd37,    16'd41,    16'd45,    16'd50,    16'd55,    16'd60,    16'd66,
    16'd73,    16'd80,    16'd88,    16'd97,    16'd107,   16'd118,   16'd130,   16'd143,
    16'd157,   16'd173,   16'd190,   16'd209,   16'd230,   16'd253,   16'd279,   16'd307,
    16'd337,   16'd371,   16'd408,   16'd449,   16'd494,   16'd544,   16'd598,   16'd658,
    16'd724,   16'd796,   16'd876,   16'd963,   16'd1060,  16'd1166,  16'd1282,  16'd1411,
    16'd1552,  16'd1707,  16'd1878,  16'd2066,  16'd2272,  16'd2499,  16'd2749,  16'd3024,
    16'd3327,  16'd3660,  16'd4026,  16'd4428,  16'd4871,  16'd5358,  16'd5894,  16'd6484,
    16'd7132,  16'd7845,  16'd8630,  16'd9493,  16'd10442, 16'd11487, 16'd12635, 16'd13899,
    16'd15289, 16'd16818, 16'd18500, 16'd20350, 16'd22385, 16'd24623, 16'd27086, 16'd29794,
    16'd32767
  };

  localparam logic signed [4:0] INDEX_TABLE [0:7] = '{
    -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
  };

  typedef struct packed {
    logic signed [15:0] pred;
    logic [6:0]         index;
  } ch_state_t;

  typedef enum logic [2:0] {IDLE, DIFF, QUANT, UPD, OUT} enc_state_e;

endpackage

// File: rtl/adpcm_step_rom.sv
// Combinational IMA step-size lookup; out-of-range indices return the largest step.
module adpcm_step_rom
  import adpcm_pkg::*;
(
  input  logic [6:0]  index,
  output logic [15:0] step
);

  // Table lookup with a clamp for indices above the table end
  always_comb begin
    if (index <= 7'(MAX_INDEX)) begin
      step = STEP_TABLE[index];
    end else begin
      step = STEP_TABLE[MAX_INDEX];
    end
  end

endmodule

// File: rtl/adpcm_mc_encoder.sv
// Time-multiplexed IMA ADPCM encoder: NUM_CH channels share one quantiser; each
// sample walks DIFF, three QUANT cycles and UPD, then waits in OUT until taken.
module adpcm_mc_encoder
  import adpcm_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  input  logic [CH_W-1:0]            in_ch,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CODE_W-1:0]          out_code,
  output logic [CH_W-1:0]            out_ch,
  input  logic                       ch_clear,
  input  logic [CH_W-1:0]            ch_clear_id,
  output logic                       err_badch
);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_DIFF  = DIFF;
  localparam logic [2:0] ST_QUANT = QUANT;
  localparam logic [2:0] ST_UPD   = UPD;
  localparam logic [2:0] ST_OUT   = OUT;

  logic [2:0]         state_r;
  logic [1:0]         qcnt_r;
  logic [CH_W-1:0]    ch_r;
  logic signed [15:0] sample_r;
  logic signed [15:0] pred_r;
  logic [6:0]         index_r;
  logic               sign_r;
  logic [16:0]        mag_r;
  logic [16:0]        vpdiff_r;
  logic [15:0]        step_r;
  logic [2:0]         code_r;
  logic               kill_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [3:0]         out_code_r;
  logic [CH_W-1:0]    out_ch_r;
  logic               err_badch_r;
  ch_state_t          ch_state_r [NUM_CH];

  logic               accept_s;
  logic               in_ch_ok_s;
  logic               clr_ok_s;
  logic               wb_s;
  ch_state_t          ch_rd_s;
  logic signed [16:0] diff_s;
  logic [16:0]        mag_s;
  logic [15:0]        rom_step_s;
  logic signed [17:0] pred_sum_s;
  logic signed [15:0] pred_new_s;
  logic signed [4:0]  idx_delta_s;
  logic signed [8:0]  idx_sum_s;
  logic [6:0]         idx_new_s;

  adpcm_step_rom u_step_rom (
    .index (index_r),
    .step  (rom_step_s)
  );

  assign accept_s   = in_valid && in_ready_r;
  assign in_ch_ok_s = (32'(in_ch) < NUM_CH);
  assign clr_ok_s   = ch_clear && (32'(ch_clear_id) < NUM_CH);
  assign wb_s       = (state_r == ST_UPD) && !kill_r;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_code  = out_code_r;
  assign out_ch    = out_ch_r;
  assign err_badch = err_badch_r;

  // Channel read mux, difference/magnitude and saturating predictor/index update
  always_comb begin
    ch_rd_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_rd_s = (in_ch == CH_W'(i)) ? ch_state_r[i] : ch_rd_s;
    end

    diff_s = {sample_r[15], sample_r} - {pred_r[15], pred_r};
    mag_s  = diff_s[16] ? (17'd0 - diff_s) : diff_s;

    pred_sum_s = sign_r ? ({{2{pred_r[15]}}, pred_r} - {1'b0, vpdiff_r})
                        : ({{2{pred_r[15]}}, pred_r} + {1'b0, vpdiff_r});
    if (pred_sum_s > 18'sd32767) begin
      pred_new_s = 16'sh7FFF;
    end else if (pred_sum_s < -18'sd32768) begin
      pred_new_s = 16'sh8000;
    end else begin
      pred_new_s = pred_sum_s[15:0];
    end

    idx_delta_s = INDEX_TABLE[code_r];
    idx_sum_s   = {2'b00, index_r} + {{4{idx_delta_s[4]}}, idx_delta_s};
    if (idx_sum_s < 9'sd0) begin
      idx_new_s = 7'd0;
    end else if (idx_sum_s > 9'sd88) begin
      idx_new_s = 7'(MAX_INDEX);
    end else begin
      idx_new_s = idx_sum_s[6:0];
    end
  end

  // Encoder sequencer, quantiser datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      qcnt_r      <= 2'd0;
      ch_r        <= '0;
      sample_r    <= 16'sd0;
      pred_r      <= 16'sd0;
      index_r     <= 7'd0;
      sign_r      <= 1'b0;
      mag_r       <= 17'd0;
      vpdiff_r    <= 17'd0;
      step_r      <= 16'd0;
      code_r      <= 3'd0;
      kill_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_code_r  <= 4'd0;
      out_ch_r    <= '0;
      err_badch_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && !in_ch_ok_s) begin
            err_badch_r <= 1'b1;
          end else if (accept_s) begin
            sample_r   <= in_sample;
            ch_r       <= in_ch;
            pred_r     <= ch_rd_s.pred;
            index_r    <= ch_rd_s.index;
            kill_r     <= clr_ok_s && (ch_clear_id == in_ch);
            in_ready_r <= 1'b0;
            state_r    <= ST_DIFF;
          end
        end
        ST_DIFF: begin
          sign_r   <= diff_s[16];
          mag_r    <= mag_s;
          step_r   <= rom_step_s;
          vpdiff_r <= {4'd0, rom_step_s[15:3]};
          code_r   <= 3'd0;
          qcnt_r   <= 2'd2;
          state_r  <= ST_QUANT;
          if (clr_ok_s && (ch_clear_id == ch_r)) kill_r <= 1'b1;
        end
        ST_QUANT: begin
          if (mag_r >= {1'b0, step_r}) begin
            code_r[qcnt_r] <= 1'b1;
            mag_r          <= mag_r - {1'b0, step_r};
            vpdiff_r       <= vpdiff_r + {1'b0, step_r};
          end
          step_r <= step_r >> 1;
          if (qcnt_r == 2'd0) begin
            state_r <= ST_UPD;
          end else begin
            qcnt_r <= qcnt_r - 2'd1;
          end
          if (clr_ok_s && (ch_clear_id == ch_r)) kill_r <= 1'b1;
        end
        ST_UPD: begin
          out_code_r  <= {sign_r, code_r};
          out_ch_r    <= ch_r;
          out_valid_r <= 1'b1;
          state_r     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-channel state; a clear outranks a same-cycle write-back
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset) begin
        ch_state_r[i] <= '0;
      end else if (clr_ok_s && (ch_clear_id == CH_W'(i))) begin
        ch_state_r[i] <= '0;
      end else if (wb_s && (ch_r == CH_W'(i))) begin
        ch_state_r[i] <= '{pred: pred_new_s, index: idx_new_s};
      end
    end
  end

endmodule

// File: tb/tb_adpcm_mc_encoder.sv
// Directed self-checking bench for adpcm_mc_encoder (2-channel and 3-channel instances).
module tb_adpcm_mc_encoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic signed [15:0] in_sample = 16'sd0;
  logic in_ch = 1'b0;
  logic out_ready = 1'b1;
  logic ch_clear = 1'b0;
  logic ch_clear_id = 1'b0;
  logic in_ready, out_valid, out_ch, err_badch;
  logic [3:0] out_code;

  logic in_valid3 = 1'b0;
  logic [1:0] in_ch3 = 2'd0;
  logic ch_clear3 = 1'b0;
  logic [1:0] ch_clear_id3 = 2'd0;
  logic in_ready3, out_valid3, err_badch3;
  logic [1:0] out_ch3;
  logic [3:0] out_code3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adpcm_mc_encoder #(.NUM_CH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .in_ch(in_ch), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_ch(out_ch), .ch_clear(ch_clear), .ch_clear_id(ch_clear_id),
    .err_badch(err_badch)
  );

  adpcm_mc_encoder #(.NUM_CH(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_sample(in_sample), .in_ch(in_ch3), .out_valid(out_valid3), .out_ready(out_ready),
    .out_code(out_code3), .out_ch(out_ch3), .ch_clear(ch_clear3), .ch_clear_id(ch_clear_id3),
    .err_badch(err_badch3)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic get_st(input int ch, output logic [15:0] p, output logic [6:0] ix);
    if (ch == 0) begin
      p = dut.ch_state_r[0].pred;
      ix = dut.ch_state_r[0].index;
    end else begin
      p = dut.ch_state_r[1].pred;
      ix = dut.ch_state_r[1].index;
    end
  endtask

  // lat = edges after the accepting edge until out_valid is seen; clear pulses at lat == clr_at
  task automatic send(input logic ch, input logic [15:0] smp, input int clr_at, input logic clr_id,
                      output logic [3:0] code, output logic och, output int lat);
    int wait_n = 0;
    @(negedge clk);
    while (!in_ready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    in_valid = 1'b1;
    in_sample = smp;
    in_ch = ch;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      ch_clear = (lat == clr_at);
      ch_clear_id = clr_id;
      @(negedge clk);
      lat++;
    end
    ch_clear = 1'b0;
    code = out_code;
    och = out_ch;
  endtask

  task automatic test_reset();
    logic [15:0] p;
    logic [6:0] ix;
    do_reset();
    checks++;
    if ({in_ready, out_valid, out_code, out_ch, err_badch} !== 8'b1_0_0000_0_0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b code=%h ch=%b err=%b", in_ready, out_valid, out_code, out_ch, err_badch);
    end
    for (int c = 0; c < 2; c++) begin
      get_st(c, p, ix);
      checks++;
      if (p !== 16'd0 || ix !== 7'd0) begin
        errors++;
        $display("FAIL reset_state ch%0d got pred=%0d idx=%0d exp 0/0", c, $signed(p), ix);
      end
    end
  endtask

  task automatic test_zero();
    logic [3:0] code;
    logic och;
    int lat;
    logic [15:0] p;
    logic [6:0] ix;
    do_reset();
    send(1'b0, 16'h0000, -1, 1'b0, code, och, lat);
    checks++;
    if (code !== 4'h0 || och !== 1'b0 || lat !== 5) begin
      errors++;
      $display("FAIL zero_sample got code=%h ch=%b lat=%0d exp 0/0/5", code, och, lat);
    end
    get_st(0, p, ix);
    checks++;
    if (p !== 16'd0 || ix !== 7'd0) begin
      errors++;
      $display("FAIL zero_state got pred=%0d idx=%0d exp 0/0", $signed(p), ix);
    end
  endtask

  task automatic test_twice();
    logic [3:0] code;
    logic och;
    int lat;
    logic [15:0] p;
    logic [6:0] ix;
    do_reset();
    send(1'b0, 16'h1000, -1, 1'b0, code, och, lat);
    get_st(0, p, ix);
    checks++;
    if (code !== 4'h7 || lat !== 5 || p !== 16'd11 || ix !== 7'd8) begin
      errors++;
      $display("FAIL twice_first got code=%h lat=%0d pred=%0d idx=%0d exp 7/5/11/8", code, lat, $signed(p), ix);
    end
    send(1'b0, 16'h1000, -1, 1'b0, code, och, lat);
    get_st(0, p, ix);
    checks++;
    if (code !== 4'h7 || p !== 16'd41 || ix !== 7'd16) begin
      errors++;
      $display("FAIL twice_second got code=%h pred=%0d idx=%0d exp 7/41/16", code, $signed(p), ix);
    end
  endtask

  task automatic test_neg_ch1();
    logic [3:0] code;
    logic och;
    int lat;
    logic [15:0] p;
    logic [6:0] ix;
    do_reset();
    send(1'b1, 16'h8000, -1, 1'b0, code, och, lat);
    checks++;
    if (code !== 4'hF || och !== 1'b1) begin
      errors++;
      $display("FAIL neg_code got code=%h ch=%b exp F/1", code, och);
    end
    get_st(1, p, ix);
    checks++;
    if (p !== 16'hFFF5 || ix !== 7'd8) begin
      errors++;
      $display("FAIL neg_state1 got pred=%0d idx=%0d exp -11/8", $signed(p), ix);
    end
    get_st(0, p, ix);
    checks++;
    if (p !== 16'd0 || ix !== 7'd0) begin
      errors++;
      $display("FAIL neg_isolation got ch0 pred=%0d idx=%0d exp 0/0", $signed(p), ix);
    end
  endtask

  task automatic test_interleave();
    logic [3:0] code;
    logic och;
    int lat;
    logic [15:0] p;
    logic [6:0] ix;
    logic [4:0] exp_v [3];
    logic [4:0] got_v [3];
    exp_v[0] = 5'b0_0111;
    exp_v[1] = 5'b1_1111;
    exp_v[2] = 5'b0_0111;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      send(exp_v[k][4], (k == 1) ? 16'h8000 : 16'h1000, -1, 1'b0, code, och, lat);
      got_v[k] = {och, code};
      checks++;
      if (got_v[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL interleave_%0d got ch=%b code=%h exp ch=%b code=%h", k, och, code, exp_v[k][4], exp_v[k][3:0]);
      end
    end
    get_st(0, p, ix);
    checks++;
    if (p !== 16'd41 || ix !== 7'd16) begin
      errors++;
      $display("FAIL interleave_ch0 got pred=%0d idx=%0d exp 41/16", $signed(p), ix);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] code;
    logic och;
    int lat;
    int bad = 0;
    do_reset();
    out_ready = 1'b0;
    send(1'b0, 16'h1000, -1, 1'b0, code, och, lat);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_code !== 4'h7 || out_ch !== 1'b0 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable got %0d unstable cycles, last vld=%b code=%h rdy=%b exp 0", bad, out_valid, out_code, in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release got rdy=%b vld=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_clear();
    logic [3:0] code;
    logic och;
    int lat;
    logic [15:0] p;
    logic [6:0] ix;
    do_reset();
    send(1'b0, 16'h1000, 4, 1'b0, code, och, lat);
    get_st(0, p, ix);
    checks++;
    if (code !== 4'h7 || p !== 16'd0 || ix !== 7'd0) begin
      errors++;
      $display("FAIL clear_upd got code=%h pred=%0d idx=%0d exp 7/0/0", code, $signed(p), ix);
    end
    send(1'b0, 16'h1000, 2, 1'b0, code, och, lat);
    get_st(0, p, ix);
    checks++;
    if (code !== 4'h7 || p !== 16'd0 || ix !== 7'd0) begin
      errors++;
      $display("FAIL clear_quant got code=%h pred=%0d idx=%0d exp 7/0/0", code, $signed(p), ix);
    end
    send(1'b1, 16'h8000, -1, 1'b0, code, och, lat);
    send(1'b0, 16'h1000, 2, 1'b1, code, och, lat);
    get_st(0, p, ix);
    checks++;
    if (p !== 16'd11 || ix !== 7'd8) begin
      errors++;
      $display("FAIL clear_other_ch0 got pred=%0d idx=%0d exp 11/8", $signed(p), ix);
    end
    get_st(1, p, ix);
    checks++;
    if (p !== 16'd0 || ix !== 7'd0) begin
      errors++;
      $display("FAIL clear_other_ch1 got pred=%0d idx=%0d exp 0/0", $signed(p), ix);
    end
  endtask

  task automatic test_badch();
    int bad = 0;
    int n = 0;
    do_reset();
    @(negedge clk);
    in_valid3 = 1'b1;
    in_ch3 = 2'd3;
    @(negedge clk);
    in_valid3 = 1'b0;
    checks++;
    if (err_badch3 !== 1'b1 || in_ready3 !== 1'b1) begin
      errors++;
      $display("FAIL badch_flag got err=%b rdy=%b exp 1/1", err_badch3, in_ready3);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid3 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL badch_no_output got %0d cycles with out_valid exp 0", bad);
    end
    in_valid3 = 1'b1;
    in_ch3 = 2'd2;
    in_sample = 16'sh1000;
    @(negedge clk);
    in_valid3 = 1'b0;
    while (!out_valid3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_code3 !== 4'h7 || out_ch3 !== 2'd2 || err_badch3 !== 1'b1 || n !== 5) begin
      errors++;
      $display("FAIL badch_ch2 got code=%h ch=%0d err=%b lat=%0d exp 7/2/1/5", out_code3, out_ch3, err_badch3, n);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] code;
    logic och;
    int lat;
    int bad = 0;
    logic [15:0] p;
    logic [6:0] ix;
    do_reset();
    send(1'b0, 16'h1000, -1, 1'b0, code, och, lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_sample = 16'sh1000;
    in_ch = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_out got %0d valid cycles rdy=%b exp 0/1", bad, in_ready);
    end
    get_st(0, p, ix);
    checks++;
    if (p !== 16'd0 || ix !== 7'd0) begin
      errors++;
      $display("FAIL reset_mid_state got pred=%0d idx=%0d exp 0/0", $signed(p), ix);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_twice();
    test_neg_ch1();
    test_interleave();
    test_backpressure();
    test_clear();
    test_badch();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
